// File: rtl/bsg_flow_credit_arbiter_pkg.sv
// Shared types and width helpers for the flow credit arbiter slice.
// Latency: n/a (types and constant functions only).
// Backpressure: n/a.
package bsg_flow_credit_arbiter_pkg;

    // Arbiter operating mode: granting, emptying the shared buffer, or held empty.
    typedef enum logic [1:0] {
        RUN     = 2'd0,
        DRAIN   = 2'd1,
        DRAINED = 2'd2
    } bsg_flow_state_e;

    // Bits needed to index n things; never returns 0 so single-entry
    // configurations still get a legal 1-bit vector.
    function automatic int lg_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    localparam int num_req_default_lp = 4;
    localparam int els_default_lp     = 64;
    localparam int lg_req_default_lp  = lg_width(num_req_default_lp);
    localparam int lg_els_default_lp  = lg_width(els_default_lp + 1);

endpackage

// File: rtl/bsg_flow_credit_arbiter_if.sv
// Requester/downstream handshake bundle for the flow credit arbiter.
// Latency: n/a (wires only).
// Backpressure: v_o/ready_i downstream, v_i/yumi_o upstream; deq_i returns credits.
// master = arbiter side, slave = requesters + downstream buffer side.
interface bsg_flow_credit_arbiter_if
    import bsg_flow_credit_arbiter_pkg::*;
#(
    parameter int num_req_p = 4,
    localparam int lg_req_lp = lg_width(num_req_p)
);
    logic [num_req_p-1:0] v_i;
    logic [num_req_p-1:0] yumi_o;
    logic                 v_o;
    logic [lg_req_lp-1:0] grant_id_o;
    logic                 ready_i;
    logic                 deq_i;
    logic [lg_req_lp-1:0] deq_id_i;

    modport master (
        input  v_i, ready_i, deq_i, deq_id_i,
        output yumi_o, v_o, grant_id_o
    );

    modport slave (
        output v_i, ready_i, deq_i, deq_id_i,
        input  yumi_o, v_o, grant_id_o
    );
endinterface

// File: rtl/bsg_counter_up_down.sv
// Saturation-free up/down counter used for buffer occupancy tracking.
// Latency: count_o reflects up_i/down_i one clk_i edge later.
// Backpressure: none; callers must never step past 0 or max_val_p.
// Ports: clk_i, reset_i (sync, active-high), up_i, down_i, count_o.
module bsg_counter_up_down
    import bsg_flow_credit_arbiter_pkg::*;
#(
    parameter int max_val_p  = 64,
    parameter int init_val_p = 0,
    parameter int max_step_p = 1,
    localparam int step_width_lp = lg_width(max_step_p + 1),
    localparam int width_lp      = lg_width(max_val_p + 1)
) (
    input  logic                     clk_i,
    input  logic                     reset_i,
    input  logic [step_width_lp-1:0] up_i,
    input  logic [step_width_lp-1:0] down_i,
    output logic [width_lp-1:0]      count_o
);
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            count_o <= width_lp'(init_val_p);
        end else begin
            count_o <= count_o + width_lp'(up_i) - width_lp'(down_i);
        end
    end
endmodule

// File: rtl/bsg_flow_credit_arbiter.sv
// Round-robin arbiter granting requesters into one shared credit-tracked buffer.
// Latency: v_o/grant_id_o/yumi_o combinational from v_i; counts and state update next edge.
// Backpressure: grants gated by ready_i, per-requester and total credit limits, and drain.
// Ports: clk_i, reset_i, link (handshake bundle), drain_i, drained_o, count_o, full_o.
module bsg_flow_credit_arbiter
    import bsg_flow_credit_arbiter_pkg::*;
#(
    parameter int num_req_p     = 4,
    parameter int els_p         = 64,
    parameter int per_req_max_p = 16,
    localparam int lg_req_lp = lg_width(num_req_p),
    localparam int lg_els_lp = lg_width(els_p + 1),
    localparam int lg_per_lp = lg_width(per_req_max_p + 1)
) (
    input  logic                      clk_i,
    input  logic                      reset_i,
    bsg_flow_credit_arbiter_if.master link,
    input  logic                      drain_i,
    output logic                      drained_o,
    output logic [lg_els_lp-1:0]      count_o,
    output logic [num_req_p-1:0]      full_o
);
    localparam logic [lg_els_lp-1:0] els_lp     = lg_els_lp'(els_p);
    localparam logic [lg_per_lp-1:0] per_max_lp = lg_per_lp'(per_req_max_p);

    bsg_flow_state_e       state_r;
    logic [lg_req_lp-1:0]  last_grant_r;
    logic [lg_per_lp-1:0]  req_cnt [num_req_p];
    logic [num_req_p-1:0]  elig;
    logic [num_req_p-1:0]  yumi;
    logic                  found_hi, found_lo;
    logic [lg_req_lp-1:0]  hi_id, lo_id, grant_id;
    logic                  v, xfer;
    logic [lg_els_lp-1:0]  count_next;

    // Reset is folded in so nothing is offered while reset_i is high.
    always_comb begin
        elig = '0;
        for (int i = 0; i < num_req_p; i++) begin
            elig[i] = link.v_i[i] & ~full_o[i] & (count_o < els_lp)
                    & (state_r == RUN) & ~reset_i;
        end
    end

    // Round robin without modulo arithmetic: the lowest eligible index above
    // last_grant wins, otherwise wrap to the lowest eligible at or below it.
    // Scanning downward lets the last hit in each half be the lowest index.
    always_comb begin
        found_hi = 1'b0;
        found_lo = 1'b0;
        hi_id    = '0;
        lo_id    = '0;
        for (int i = num_req_p - 1; i >= 0; i--) begin
            if (elig[i]) begin
                if (i > int'(last_grant_r)) begin
                    found_hi = 1'b1;
                    hi_id    = lg_req_lp'(i);
                end else begin
                    found_lo = 1'b1;
                    lo_id    = lg_req_lp'(i);
                end
            end
        end
    end

    assign grant_id = found_hi ? hi_id : lo_id;
    assign v        = found_hi | found_lo;
    assign xfer     = v & link.ready_i;

    always_comb begin
        yumi = '0;
        if (xfer) begin
            yumi[grant_id] = 1'b1;
        end
    end

    assign link.v_o        = v;
    assign link.grant_id_o = grant_id;
    assign link.yumi_o     = yumi;

    // Occupancy after this edge; lets drain finish on the same edge that
    // returns the last credit.
    assign count_next = count_o + lg_els_lp'(xfer) - lg_els_lp'(link.deq_i);

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            last_grant_r <= lg_req_lp'(num_req_p - 1);
        end else if (xfer) begin
            last_grant_r <= grant_id;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_r   <= RUN;
            drained_o <= 1'b0;
        end else begin
            case (state_r)
                RUN: begin
                    if (drain_i) begin
                        if (count_next == '0) begin
                            state_r   <= DRAINED;
                            drained_o <= 1'b1;
                        end else begin
                            state_r   <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if (!drain_i) begin
                        state_r   <= RUN;
                    end else if (count_next == '0) begin
                        state_r   <= DRAINED;
                        drained_o <= 1'b1;
                    end
                end
                DRAINED: begin
                    if (!drain_i) begin
                        state_r   <= RUN;
                        drained_o <= 1'b0;
                    end
                end
                default: begin
                    state_r   <= RUN;
                    drained_o <= 1'b0;
                end
            endcase
        end
    end

    bsg_counter_up_down #(
        .max_val_p (els_p),
        .init_val_p(0),
        .max_step_p(1)
    ) total_cnt (
        .clk_i  (clk_i),
        .reset_i(reset_i),
        .up_i   (xfer),
        .down_i (link.deq_i),
        .count_o(count_o)
    );

    for (genvar g = 0; g < num_req_p; g++) begin : g_req
        logic up, dn;
        assign up = xfer & (grant_id == lg_req_lp'(g));
        assign dn = link.deq_i & (link.deq_id_i == lg_req_lp'(g));

        bsg_counter_up_down #(
            .max_val_p (per_req_max_p),
            .init_val_p(0),
            .max_step_p(1)
        ) req_cnt_u (
            .clk_i  (clk_i),
            .reset_i(reset_i),
            .up_i   (up),
            .down_i (dn),
            .count_o(req_cnt[g])
        );

        assign full_o[g] = (req_cnt[g] == per_max_lp);
    end

    // A credit return for an empty owner would wrap the counters.
    deq_nonzero_a: assert property (@(posedge clk_i) disable iff (reset_i)
        link.deq_i |-> ((count_o != '0) && (req_cnt[link.deq_id_i] != '0)));

endmodule

// File: tb/tb_bsg_flow_credit_arbiter.sv
module tb_bsg_flow_credit_arbiter;
    logic       clk_i = 1'b0;
    logic       reset_i;
    logic       drain_i;
    logic       drained_o;
    logic [6:0] count_o;
    logic [3:0] full_o;

    int checks   = 0;
    int failures = 0;

    localparam int exp_rr[8]      = '{0, 1, 2, 3, 0, 1, 2, 3};
    localparam int exp_rr_yumi[8] = '{1, 2, 4, 8, 1, 2, 4, 8};
    localparam int drain_ids[5]   = '{0, 0, 1, 2, 3};
    localparam int drain_cnt[5]   = '{4, 3, 2, 1, 0};
    localparam int drain_done[5]  = '{0, 0, 0, 0, 1};

    bsg_flow_credit_arbiter_if #(.num_req_p(4)) link ();

    bsg_flow_credit_arbiter #(
        .num_req_p    (4),
        .els_p        (64),
        .per_req_max_p(16)
    ) dut (
        .clk_i    (clk_i),
        .reset_i  (reset_i),
        .link     (link),
        .drain_i  (drain_i),
        .drained_o(drained_o),
        .count_o  (count_o),
        .full_o   (full_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
        end
    endtask

    task automatic cyc();
        @(posedge clk_i);
        #1;
    endtask

    task automatic do_reset();
        reset_i       = 1'b1;
        drain_i       = 1'b0;
        link.v_i      = 4'h0;
        link.ready_i  = 1'b0;
        link.deq_i    = 1'b0;
        link.deq_id_i = 2'd0;
        cyc();
        cyc();
        reset_i = 1'b0;
        #1;
    endtask

    initial begin
        // Reset with every requester pushing: nothing may be offered.
        reset_i       = 1'b1;
        drain_i       = 1'b0;
        link.v_i      = 4'hF;
        link.ready_i  = 1'b1;
        link.deq_i    = 1'b0;
        link.deq_id_i = 2'd0;
        #2;
        check("rst_v_o", link.v_o, 0);
        check("rst_yumi", link.yumi_o, 0);
        cyc();
        cyc();
        reset_i = 1'b0;
        #1;
        check("rst_count", count_o, 0);
        check("rst_drained", drained_o, 0);
        check("rst_full", full_o, 0);

        // Round robin across four always-valid requesters.
        for (int k = 0; k < 8; k++) begin
            check("rr_v_o", link.v_o, 1);
            check($sformatf("rr_grant_%0d", k), link.grant_id_o, exp_rr[k]);
            check($sformatf("rr_yumi_%0d", k), link.yumi_o, exp_rr_yumi[k]);
            cyc();
        end
        link.v_i = 4'h0;
        #1;
        check("rr_count", count_o, 8);
        check("rr_full", full_o, 0);
        check("rr_idle_v_o", link.v_o, 0);

        // Single requester hits its per-requester limit, then one credit back.
        do_reset();
        link.v_i     = 4'b0100;
        link.ready_i = 1'b1;
        #1;
        for (int k = 0; k < 16; k++) begin
            check("solo_v_o", link.v_o, 1);
            check("solo_grant", link.grant_id_o, 2);
            cyc();
        end
        check("solo_full", full_o, 4'b0100);
        check("solo_blocked_v_o", link.v_o, 0);
        check("solo_count16", count_o, 16);
        link.deq_i    = 1'b1;
        link.deq_id_i = 2'd2;
        #1;
        check("solo_deq_cycle_v_o", link.v_o, 0);
        cyc();
        link.deq_i = 1'b0;
        #1;
        check("solo_count15", count_o, 15);
        check("solo_unfull", full_o, 0);
        check("solo_regrant_v_o", link.v_o, 1);
        check("solo_regrant_id", link.grant_id_o, 2);
        cyc();
        check("solo_refill_count", count_o, 16);
        check("solo_refill_v_o", link.v_o, 0);

        // Fill the whole buffer, then simultaneous grant and credit return.
        do_reset();
        link.v_i     = 4'hF;
        link.ready_i = 1'b1;
        repeat (64) cyc();
        check("fill_count64", count_o, 64);
        check("fill_full", full_o, 4'hF);
        check("fill_v_o", link.v_o, 0);
        link.v_i      = 4'h0;
        link.deq_i    = 1'b1;
        link.deq_id_i = 2'd0;
        cyc();
        link.v_i      = 4'hF;
        link.deq_id_i = 2'd1;
        #1;
        check("fill_count63", count_o, 63);
        check("fill_full_r0_free", full_o, 4'b1110);
        check("fill_xdeq_v_o", link.v_o, 1);
        check("fill_xdeq_grant", link.grant_id_o, 0);
        cyc();
        check("fill_xdeq_count", count_o, 63);
        check("fill_xdeq_full", full_o, 4'b1101);
        link.v_i = 4'b0010;
        #1;
        check("fill_same_grant", link.grant_id_o, 1);
        cyc();
        link.v_i   = 4'h0;
        link.deq_i = 1'b0;
        #1;
        check("fill_same_count", count_o, 63);
        check("fill_same_full", full_o, 4'b1101);

        // Drain with five outstanding elements.
        do_reset();
        link.v_i     = 4'hF;
        link.ready_i = 1'b1;
        repeat (5) cyc();
        link.v_i = 4'h0;
        drain_i  = 1'b1;
        #1;
        check("drain_start_count", count_o, 5);
        cyc();
        link.v_i = 4'hF;
        #1;
        check("drain_v_o", link.v_o, 0);
        check("drain_yumi", link.yumi_o, 0);
        check("drain_not_done", drained_o, 0);
        for (int k = 0; k < 5; k++) begin
            link.deq_i    = 1'b1;
            link.deq_id_i = 2'(drain_ids[k]);
            #1;
            check($sformatf("drain_deq_v_o_%0d", k), link.v_o, 0);
            cyc();
            check($sformatf("drain_count_%0d", k), count_o, drain_cnt[k]);
            check($sformatf("drain_done_%0d", k), drained_o, drain_done[k]);
        end
        link.deq_i = 1'b0;
        #1;
        check("drained_v_o", link.v_o, 0);
        drain_i = 1'b0;
        cyc();
        check("undrain_drained", drained_o, 0);
        check("undrain_v_o", link.v_o, 1);
        check("undrain_grant", link.grant_id_o, 1);

        // Reset in the middle of a drain with ten outstanding.
        do_reset();
        link.v_i     = 4'hF;
        link.ready_i = 1'b1;
        repeat (10) cyc();
        link.v_i = 4'h0;
        drain_i  = 1'b1;
        cyc();
        link.v_i = 4'hF;
        #1;
        check("mid_count10", count_o, 10);
        check("mid_in_drain_v_o", link.v_o, 0);
        check("mid_drained", drained_o, 0);
        reset_i       = 1'b1;
        drain_i       = 1'b0;
        link.deq_i    = 1'b1;
        link.deq_id_i = 2'd0;
        #1;
        check("mid_rst_v_o", link.v_o, 0);
        check("mid_rst_yumi", link.yumi_o, 0);
        cyc();
        reset_i    = 1'b0;
        link.deq_i = 1'b0;
        #1;
        check("mid_post_count", count_o, 0);
        check("mid_post_drained", drained_o, 0);
        check("mid_post_full", full_o, 0);
        check("mid_post_v_o", link.v_o, 1);
        check("mid_post_grant", link.grant_id_o, 0);
        check("mid_post_yumi", link.yumi_o, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
